// File: rtl/usr_ctrl_debouncer.sv
// Pushbutton/switch front end for the universal shift register: synchronises and
// debounces three buttons and turns each accepted press into a one-cycle ctrl code with d.
module usr_ctrl_debouncer #(
    parameter int unsigned N            = 8,
    parameter int unsigned STABLE_TICKS = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic         btn_load,
    input  logic [N-1:0] sw,
    output logic [1:0]   ctrl,
    output logic [N-1:0] d,
    output logic [2:0]   db_level
);

    localparam int unsigned   CW       = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] CNT_TERM = CW'(STABLE_TICKS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ZERO,
        WAIT1,
        ONE,
        WAIT0
    } db_state_t;

    logic [2:0]    btn_raw;
    logic [2:0]    btn_m;
    logic [2:0]    btn_s;
    logic [N-1:0]  sw_m;
    logic [N-1:0]  sw_s;

    db_state_t     state    [3];
    db_state_t     state_nx [3];
    logic [CW-1:0] cnt      [3];
    logic [CW-1:0] cnt_nx   [3];
    logic [2:0]    rise;
    logic [1:0]    ctrl_nx;

    // Bit order {load, right, left} matches db_level.
    assign btn_raw = {btn_load, btn_right, btn_left};

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_m <= '0;
            btn_s <= '0;
            sw_m  <= '0;
            sw_s  <= '0;
        end else begin
            btn_m <= btn_raw;
            btn_s <= btn_m;
            sw_m  <= sw;
            sw_s  <= sw_m;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 3; i++) begin
            if (rst) begin
                state[i] <= ZERO;
                cnt[i]   <= '0;
            end else begin
                state[i] <= state_nx[i];
                cnt[i]   <= cnt_nx[i];
            end
        end
    end

    always_comb begin
        rise = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            state_nx[i] = state[i];
            cnt_nx[i]   = cnt[i];
            unique case (state[i])
                ZERO: begin
                    if (btn_s[i]) begin
                        state_nx[i] = WAIT1;
                        cnt_nx[i]   = CNT_ONE;
                    end
                end
                WAIT1: begin
                    if (!btn_s[i]) begin
                        state_nx[i] = ZERO;
                        cnt_nx[i]   = '0;
                    end else if (cnt[i] == CNT_TERM) begin
                        state_nx[i] = ONE;
                        cnt_nx[i]   = '0;
                        rise[i]     = 1'b1;
                    end else begin
                        cnt_nx[i] = cnt[i] + CNT_ONE;
                    end
                end
                ONE: begin
                    if (!btn_s[i]) begin
                        state_nx[i] = WAIT0;
                        cnt_nx[i]   = CNT_ONE;
                    end
                end
                WAIT0: begin
                    if (btn_s[i]) begin
                        state_nx[i] = ONE;
                        cnt_nx[i]   = '0;
                    end else if (cnt[i] == CNT_TERM) begin
                        state_nx[i] = ZERO;
                        cnt_nx[i]   = '0;
                    end else begin
                        cnt_nx[i] = cnt[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_nx[i] = ZERO;
                    cnt_nx[i]   = '0;
                end
            endcase
        end
    end

    always_comb begin
        db_level = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            db_level[i] = (state[i] == ONE) || (state[i] == WAIT0);
        end
    end

    // Fixed priority; simultaneous lower-priority rises are dropped.
    always_comb begin
        ctrl_nx = 2'b00;
        if (rise[2]) begin
            ctrl_nx = 2'b11;
        end else if (rise[0]) begin
            ctrl_nx = 2'b01;
        end else if (rise[1]) begin
            ctrl_nx = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl <= 2'b00;
            d    <= '0;
        end else begin
            ctrl <= ctrl_nx;
            if (ctrl_nx != 2'b00) begin
                d <= sw_s;
            end
        end
    end

endmodule
